// File: rtl/cmp2_pkg.sv
// Shared types and reference function for the 2-bit comparator self-test.
package cmp2_pkg;

    localparam int unsigned CMP_MAX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Expected {gt,eq,lt} for an unsigned compare of a against b.
    function automatic logic [2:0] cmp_ref(input logic [CMP_MAX_W-1:0] a,
                                           input logic [CMP_MAX_W-1:0] b);
        return {a > b, a == b, a < b};
    endfunction

endpackage

// File: rtl/cmp2_bist_scoreboard.sv
// Result checker: flags mismatching vectors, counts them and latches the first one.
module cmp2_bist_scoreboard
    import cmp2_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               check_en,
    input  logic               finish,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               dut_gt,
    input  logic               dut_eq,
    input  logic               dut_lt,
    output logic [2*WIDTH:0]   fail_count,
    output logic [WIDTH-1:0]   first_fail_a,
    output logic [WIDTH-1:0]   first_fail_b,
    output logic               pass
);

    localparam int unsigned VEC_W = 2 * WIDTH;
    localparam int unsigned FC_W  = VEC_W + 1;
    localparam logic [FC_W-1:0] FAIL_MAX = FC_W'(1 << VEC_W);

    logic fail_c;

    always_comb begin
        fail_c = check_en &&
                 ({dut_gt, dut_eq, dut_lt} != cmp_ref(CMP_MAX_W'(a), CMP_MAX_W'(b)));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fail_count   <= '0;
            first_fail_a <= '0;
            first_fail_b <= '0;
            pass         <= 1'b0;
        end else begin
            if (fail_c) begin
                if (fail_count != FAIL_MAX) begin
                    fail_count <= fail_count + FC_W'(1);
                end
                if (fail_count == '0) begin
                    first_fail_a <= a;
                    first_fail_b <= b;
                end
            end
            // Last vector is checked on the same edge that enters DONE.
            if (finish) begin
                pass <= (fail_count == '0) && !fail_c;
            end
        end
    end

endmodule

// File: rtl/cmp2_bist_ctrl.sv
// Exhaustive self-test driver for the 2-bit comparator: sequences operands,
// waits a settle window, and hands each result to the scoreboard.
module cmp2_bist_ctrl
    import cmp2_pkg::*;
#(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               dut_gt,
    input  logic               dut_eq,
    input  logic               dut_lt,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   fail_count,
    output logic [WIDTH-1:0]   first_fail_a,
    output logic [WIDTH-1:0]   first_fail_b
);

    localparam int unsigned VEC_W = 2 * WIDTH;
    localparam int unsigned CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    state_t            state, state_nxt;
    logic [VEC_W-1:0]  vec;
    logic [CNT_W-1:0]  settle_cnt;
    logic              start_run_c;
    logic              step_c;
    logic              check_c;
    logic              finish_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_run_c = 1'b0;
        step_c      = 1'b0;
        check_c     = 1'b0;
        finish_c    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_run_c = 1'b1;
                    state_nxt   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == CNT_W'(1)) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                check_c = 1'b1;
                if (vec == '1) begin
                    finish_c  = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    step_c    = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operands only move on the edge entering SETTLE; a is the outer loop.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= '0;
            settle_cnt <= '0;
            a_out      <= '0;
            b_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (start_run_c) begin
                vec            <= '0;
                settle_cnt     <= CNT_W'(SETTLE_CYCLES);
                {a_out, b_out} <= '0;
            end else if (step_c) begin
                vec            <= vec + VEC_W'(1);
                settle_cnt     <= CNT_W'(SETTLE_CYCLES);
                {a_out, b_out} <= vec + VEC_W'(1);
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end
            busy <= (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK);
            done <= (state_nxt == ST_DONE);
        end
    end

    cmp2_bist_scoreboard #(
        .WIDTH (WIDTH)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .clear        (start_run_c),
        .check_en     (check_c),
        .finish       (finish_c),
        .a            (a_out),
        .b            (b_out),
        .dut_gt       (dut_gt),
        .dut_eq       (dut_eq),
        .dut_lt       (dut_lt),
        .fail_count   (fail_count),
        .first_fail_a (first_fail_a),
        .first_fail_b (first_fail_b),
        .pass         (pass)
    );

endmodule
